digital_lock_core: RTL and testbench
====================================

# digital_lock_core

Parametrised lock controller that supersedes the fixed four-digit, fixed-password lock FSM. It sits between the keypad/button pulse logic and the LED/RGB/servo/SSD consumers in the top level. Compared with the fixed FSM, it adds:
- configurable code length;
- in-field re-programming of the code with confirmation;
- a timed auto-relock;
- a failed-attempt lockout with a countdown.

## Interface
Parameters:
- clk_freq, 50_000_000, clock frequency in Hz.
- digits, 4, code length in decimal digits (1..8).
- max_tries, 3, consecutive failed entries that trigger lockout (1..15).
- unlock_sec, 5, auto-relock time in OPEN.
- lockout_sec, 30, LOCKOUT duration.
- default_code, 32'h0000_1234, reset code; the low 4*digits bits are used, packed as BCD with the most recent digit in the LSB nibble.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle pulse; key_value is valid.
- key_value  in  4  keypad code; only 0..9 are accepted, other values are ignored.
- cmd_enter  in  1  one-cycle pulse: submit entry.
- cmd_clear  in  1  one-cycle pulse: discard entry.
- cmd_program  in  1  one-cycle pulse: start re-programming (OPEN only).
- relock  in  1  one-cycle pulse: force LOCKED from OPEN/PROG1/PROG2.
- entry  out  4*digits  digits typed so far, for SSD display.
- digit_cnt  out  $clog2(digits+1)  number of digits typed.
- fail_cnt  out  4  consecutive failures.
- unlocked  out  1  high in OPEN only; drives the servo.
- lockout  out  1  high in LOCKOUT.
- led  out  4  one-hot state: [0] LOCKED, [1] OPEN, [2] PROG1/PROG2, [3] LOCKOUT.
- rgb  out  3  LOCKED 3'b001, OPEN 3'b010, PROG 3'b011, LOCKOUT 3'b100.

## Operation
States: LOCKED, OPEN, PROG1, PROG2, LOCKOUT.

Digit entry (LOCKED, PROG1, PROG2):
- A key_valid with value ≤ 9 while digit_cnt < digits does: entry <= {entry[4*digits-5:0], key_value}; digit_cnt++.
- Extra digits beyond digits, and values > 9, are dropped.
- cmd_clear: entry = 0, digit_cnt = 0.

Transitions:
- LOCKED + cmd_enter, digit_cnt == digits and entry == code: go to OPEN; fail_cnt = 0; load timer with clk_freq*unlock_sec.
- LOCKED + cmd_enter otherwise (wrong code or short entry): fail_cnt++.
  - If the new fail_cnt == max_tries: go to LOCKOUT and load timer with clk_freq*lockout_sec.
  - In all cases the entry is cleared.
- OPEN:
  - Timer reaching 0, or relock: go to LOCKED.
  - cmd_program: go to PROG1.
  - Keys are ignored.
- PROG1 + cmd_enter with a full entry: pending = entry; go to PROG2. A short entry is ignored, except that the entry is cleared.
- PROG2 + cmd_enter with a full entry equal to pending: code = pending; go to LOCKED.
- PROG2 + cmd_enter otherwise: go to OPEN with the code unchanged and the timer reloaded.
- PROG1/PROG2 + relock: go to LOCKED with the code unchanged. No timeout applies in PROG.
- LOCKOUT: all inputs are ignored. When the timer reaches 0, go to LOCKED with fail_cnt = 0.
- Every state change clears entry and digit_cnt.

Same-cycle priority: relock > cmd_clear > cmd_enter > cmd_program > key_valid. The loser is dropped, not queued.

## Timing
- All outputs are registered. The effect of an input pulse is visible on the first clk edge after it (1-cycle latency).
- OPEN lasts exactly clk_freq*unlock_sec cycles. LOCKOUT lasts exactly clk_freq*lockout_sec cycles.
- Timer width: $clog2 of the larger load value plus 1. Loads truncate never; this is checked by an elaboration assertion.
- Reset (rst low, async assert, sync release) sets:
  - state LOCKED, code = default_code;
  - pending, entry, digit_cnt, fail_cnt, timer = 0;
  - unlocked = 0, lockout = 0;
  - led = 4'b0001, rgb = 3'b001.
- Reset mid-OPEN or mid-LOCKOUT aborts immediately.
- A re-programmed code is lost on reset, which restores default_code.

## Structure
- digital_lock_pkg holds:
  - lock_state_t enum;
  - LED_* and RGB_* constants;
  - a function for the BCD-valid check.
- Sub-module lock_timer: load/value in, one-cycle done pulse out, countdown only when enabled.
- Instantiated in the top level in place of the fixed FSM. Key pulses come from the existing keypad/debounce path.

## Test plan
All scenarios use clk_freq=10, digits=4, max_tries=3, unlock_sec=2, lockout_sec=3.
- Keys 1,2,3,4 then cmd_enter → unlocked=1 and led=4'b0010 one cycle later; unlocked drops after exactly 20 cycles.
- Keys 9,9,9,9 then enter, three times → fail_cnt counts 1, 2, then lockout=1. Correct code during the 30 cycles is ignored; LOCKED with fail_cnt=0 after 30 cycles.
- Keys 1,2,3,4,5 → entry=16'h1234 and digit_cnt=4; key value 4'hB is ignored. cmd_clear → entry=0.
- From OPEN: cmd_program, 5,6,7,8, enter, 5,6,7,8, enter → LOCKED. Old code 1234 now fails; 5678 opens.
- PROG2 with mismatching confirmation 5,6,7,9 → back to OPEN, code still 1234.
- cmd_enter and cmd_clear in the same cycle → clear wins, fail_cnt unchanged. Reset asserted mid-LOCKOUT → LOCKED immediately, all outputs at their reset values.

Source files
------------

// File: rtl/digital_lock_pkg.sv
// Shared types and constants for the digital lock controller.
package digital_lock_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_OPEN    = 3'd1,
        ST_PROG1   = 3'd2,
        ST_PROG2   = 3'd3,
        ST_LOCKOUT = 3'd4
    } lock_state_t;

    localparam logic [3:0] LED_LOCKED  = 4'b0001;
    localparam logic [3:0] LED_OPEN    = 4'b0010;
    localparam logic [3:0] LED_PROG    = 4'b0100;
    localparam logic [3:0] LED_LOCKOUT = 4'b1000;

    localparam logic [2:0] RGB_LOCKED  = 3'b001;
    localparam logic [2:0] RGB_OPEN    = 3'b010;
    localparam logic [2:0] RGB_PROG    = 3'b011;
    localparam logic [2:0] RGB_LOCKOUT = 3'b100;

    // True for keypad codes that are decimal digits.
    function automatic logic is_bcd_digit(input logic [3:0] v);
        return v <= 4'd9;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done_c pulses in the last counted cycle.
module lock_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Load has priority; otherwise count down to zero while enabled.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (en && (value_q != '0)) begin
            value_d = value_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    // Fires on the cycle whose closing edge brings the count to zero.
    assign done_c = en && !load && (value_q == W'(1));

endmodule

// File: rtl/digital_lock_core.sv
// Parametrised keypad lock: code entry, re-programming, auto-relock, lockout.
module digital_lock_core #(
    parameter int unsigned clk_freq     = 50_000_000,
    parameter int unsigned digits       = 4,
    parameter int unsigned max_tries    = 3,
    parameter int unsigned unlock_sec   = 5,
    parameter int unsigned lockout_sec  = 30,
    parameter logic [31:0] default_code = 32'h0000_1234
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_valid,
    input  logic [3:0]                   key_value,
    input  logic                         cmd_enter,
    input  logic                         cmd_clear,
    input  logic                         cmd_program,
    input  logic                         relock,
    output logic [4*digits-1:0]          entry,
    output logic [$clog2(digits+1)-1:0]  digit_cnt,
    output logic [3:0]                   fail_cnt,
    output logic                         unlocked,
    output logic                         lockout,
    output logic [3:0]                   led,
    output logic [2:0]                   rgb
);

    import digital_lock_pkg::*;

    localparam int unsigned     EW           = 4 * digits;
    localparam int unsigned     CW           = $clog2(digits + 1);
    localparam longint unsigned UNLOCK_LOAD  = 64'(clk_freq) * 64'(unlock_sec);
    localparam longint unsigned LOCKOUT_LOAD = 64'(clk_freq) * 64'(lockout_sec);
    localparam longint unsigned MAX_LOAD     = (UNLOCK_LOAD > LOCKOUT_LOAD) ? UNLOCK_LOAD : LOCKOUT_LOAD;
    localparam int unsigned     TW           = $clog2(MAX_LOAD) + 1;
    localparam logic [TW-1:0]   UNLOCK_VAL   = TW'(UNLOCK_LOAD);
    localparam logic [TW-1:0]   LOCKOUT_VAL  = TW'(LOCKOUT_LOAD);

    // Reject parameter sets the datapath cannot represent.
    if (digits < 1 || digits > 8) begin : g_bad_digits
        $error("digital_lock_core: digits must be in 1..8");
    end
    if (max_tries < 1 || max_tries > 15) begin : g_bad_tries
        $error("digital_lock_core: max_tries must be in 1..15");
    end
    if ((MAX_LOAD >> TW) != 64'd0) begin : g_bad_timer
        $error("digital_lock_core: timer load does not fit timer width");
    end

    lock_state_t   state_q,    state_d;
    logic [EW-1:0] code_q,     code_d;
    logic [EW-1:0] pending_q,  pending_d;
    logic [EW-1:0] entry_q,    entry_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [3:0]    fail_q,     fail_d;
    logic          unlocked_q, unlocked_d;
    logic          lockout_q,  lockout_d;
    logic [3:0]    led_q,      led_d;
    logic [2:0]    rgb_q,      rgb_d;

    logic          entry_full_c;
    logic [3:0]    fail_inc_c;
    logic          tmr_en_c;
    logic          tmr_load_c;
    logic [TW-1:0] tmr_val_c;
    logic          tmr_done_c;

    assign entry_full_c = (cnt_q == CW'(digits));
    assign tmr_en_c     = (state_q == ST_OPEN) || (state_q == ST_LOCKOUT);

    lock_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (tmr_en_c),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .done_c   (tmr_done_c)
    );

    // State, datapath and registered-output flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_LOCKED;
            code_q     <= EW'(default_code);
            pending_q  <= '0;
            entry_q    <= '0;
            cnt_q      <= '0;
            fail_q     <= '0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
            led_q      <= LED_LOCKED;
            rgb_q      <= RGB_LOCKED;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            pending_q  <= pending_d;
            entry_q    <= entry_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            unlocked_q <= unlocked_d;
            lockout_q  <= lockout_d;
            led_q      <= led_d;
            rgb_q      <= rgb_d;
        end
    end

    // Next state: LOCKOUT ignores all inputs, then relock > clear > enter > program > key.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        pending_d  = pending_q;
        entry_d    = entry_q;
        cnt_d      = cnt_q;
        fail_d     = fail_q;
        fail_inc_c = fail_q + 4'd1;
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;

        if (state_q == ST_LOCKOUT) begin
            if (tmr_done_c) begin
                state_d = ST_LOCKED;
                fail_d  = '0;
            end
        end else if (relock) begin
            if (state_q != ST_LOCKED) begin
                state_d = ST_LOCKED;
            end
        end else if ((state_q == ST_OPEN) && tmr_done_c) begin
            state_d = ST_LOCKED;
        end else if (cmd_clear) begin
            entry_d = '0;
            cnt_d   = '0;
        end else if (cmd_enter) begin
            case (state_q)
                ST_LOCKED: begin
                    entry_d = '0;
                    cnt_d   = '0;
                    if (entry_full_c && (entry_q == code_q)) begin
                        state_d    = ST_OPEN;
                        fail_d     = '0;
                        tmr_load_c = 1'b1;
                        tmr_val_c  = UNLOCK_VAL;
                    end else begin
                        fail_d = fail_inc_c;
                        if (fail_inc_c == 4'(max_tries)) begin
                            state_d    = ST_LOCKOUT;
                            tmr_load_c = 1'b1;
                            tmr_val_c  = LOCKOUT_VAL;
                        end
                    end
                end
                ST_PROG1: begin
                    entry_d = '0;
                    cnt_d   = '0;
                    if (entry_full_c) begin
                        pending_d = entry_q;
                        state_d   = ST_PROG2;
                    end
                end
                ST_PROG2: begin
                    if (entry_full_c && (entry_q == pending_q)) begin
                        code_d  = pending_q;
                        state_d = ST_LOCKED;
                    end else begin
                        state_d    = ST_OPEN;
                        tmr_load_c = 1'b1;
                        tmr_val_c  = UNLOCK_VAL;
                    end
                end
                default: ;
            endcase
        end else if (cmd_program) begin
            if (state_q == ST_OPEN) begin
                state_d = ST_PROG1;
            end
        end else if (key_valid && (state_q != ST_OPEN) && is_bcd_digit(key_value) && !entry_full_c) begin
            entry_d = (entry_q << 4) | EW'(key_value);
            cnt_d   = cnt_q + CW'(1);
        end

        // Any state change starts with an empty entry.
        if (state_d != state_q) begin
            entry_d = '0;
            cnt_d   = '0;
        end
    end

    // Output decode from the next state so outputs line up with state_q.
    always_comb begin
        unlocked_d = 1'b0;
        lockout_d  = 1'b0;
        led_d      = LED_LOCKED;
        rgb_d      = RGB_LOCKED;
        case (state_d)
            ST_OPEN: begin
                unlocked_d = 1'b1;
                led_d      = LED_OPEN;
                rgb_d      = RGB_OPEN;
            end
            ST_PROG1, ST_PROG2: begin
                led_d = LED_PROG;
                rgb_d = RGB_PROG;
            end
            ST_LOCKOUT: begin
                lockout_d = 1'b1;
                led_d     = LED_LOCKOUT;
                rgb_d     = RGB_LOCKOUT;
            end
            default: ;
        endcase
    end

    assign entry     = entry_q;
    assign digit_cnt = cnt_q;
    assign fail_cnt  = fail_q;
    assign unlocked  = unlocked_q;
    assign lockout   = lockout_q;
    assign led       = led_q;
    assign rgb       = rgb_q;

endmodule

// File: tb/tb_digital_lock_core.sv
// Scoreboard bench for digital_lock_core with small timer constants.
module tb_digital_lock_core;

    localparam int S_L = 0;  // LOCKED
    localparam int S_O = 1;  // OPEN
    localparam int S_P = 2;  // PROG1/PROG2
    localparam int S_X = 3;  // LOCKOUT

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_value;
    logic        cmd_enter;
    logic        cmd_clear;
    logic        cmd_program;
    logic        relock;
    logic [15:0] entry;
    logic [2:0]  digit_cnt;
    logic [3:0]  fail_cnt;
    logic        unlocked;
    logic        lockout;
    logic [3:0]  led;
    logic [2:0]  rgb;

    digital_lock_core #(
        .clk_freq     (10),
        .digits       (4),
        .max_tries    (3),
        .unlock_sec   (2),
        .lockout_sec  (3),
        .default_code (32'h0000_1234)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_value   (key_value),
        .cmd_enter   (cmd_enter),
        .cmd_clear   (cmd_clear),
        .cmd_program (cmd_program),
        .relock      (relock),
        .entry       (entry),
        .digit_cnt   (digit_cnt),
        .fail_cnt    (fail_cnt),
        .unlocked    (unlocked),
        .lockout     (lockout),
        .led         (led),
        .rgb         (rgb)
    );

    typedef struct {
        int unsigned at;
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc;
    int unsigned chk_cyc;
    int          n_tests;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected snapshot: {entry, digit_cnt, fail_cnt, unlocked, lockout, led, rgb}.
    task automatic push(input int unsigned at, input string nm, input int st,
                        input logic [15:0] e, input logic [2:0] n, input logic [3:0] f);
        exp_t       x;
        logic [3:0] l;
        logic [2:0] c;
        case (st)
            S_O:     begin l = 4'b0010; c = 3'b010; end
            S_P:     begin l = 4'b0100; c = 3'b011; end
            S_X:     begin l = 4'b1000; c = 3'b100; end
            default: begin l = 4'b0001; c = 3'b001; end
        endcase
        x.at   = at;
        x.name = nm;
        x.val  = {e, n, f, (st == S_O), (st == S_X), l, c};
        q.push_back(x);
    endtask

    // One-cycle input pulse; its effect is checked at chk_cyc.
    task automatic step(input logic kv, input logic [3:0] kval, input logic en,
                        input logic cl, input logic pr, input logic rl);
        @(negedge clk);
        key_valid   = kv;
        key_value   = kval;
        cmd_enter   = en;
        cmd_clear   = cl;
        cmd_program = pr;
        relock      = rl;
        chk_cyc     = cyc + 1;
        @(posedge clk);
        #1;
        key_valid   = 1'b0;
        key_value   = 4'h0;
        cmd_enter   = 1'b0;
        cmd_clear   = 1'b0;
        cmd_program = 1'b0;
        relock      = 1'b0;
    endtask

    task automatic key(input logic [3:0] v);
        step(1'b1, v, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic type4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        key(a); key(b); key(c); key(d);
    endtask

    task automatic enter();
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_cyc(input int unsigned x);
        while (cyc < x) @(negedge clk);
    endtask

    // Monitor: compare each queued expectation at its cycle.
    initial begin
        exp_t x;
        logic [31:0] obs;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].at <= cyc) begin
                x   = q.pop_front();
                obs = {entry, digit_cnt, fail_cnt, unlocked, lockout, led, rgb};
                n_tests++;
                if (x.at != cyc) begin
                    n_fail++;
                    $display("FAIL %s: check for cycle %0d reached at cycle %0d", x.name, x.at, cyc);
                end else if (obs !== x.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h (cycle %0d)", x.name, obs, x.val, cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;
        cyc = 0; n_tests = 0; n_fail = 0; chk_cyc = 0;
        rst = 1'b0;
        key_valid = 1'b0; key_value = 4'h0;
        cmd_enter = 1'b0; cmd_clear = 1'b0; cmd_program = 1'b0; relock = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        push(cyc + 1, "reset", S_L, 16'h0000, 3'd0, 4'd0);

        // Correct code opens for exactly 20 cycles.
        key(4'd1); push(chk_cyc, "key1", S_L, 16'h0001, 3'd1, 4'd0);
        key(4'd2); push(chk_cyc, "key2", S_L, 16'h0012, 3'd2, 4'd0);
        key(4'd3); push(chk_cyc, "key3", S_L, 16'h0123, 3'd3, 4'd0);
        key(4'd4); push(chk_cyc, "key4", S_L, 16'h1234, 3'd4, 4'd0);
        enter();   push(chk_cyc, "open", S_O, 16'h0000, 3'd0, 4'd0);
        c = chk_cyc;
        push(c + 19, "open_hold",   S_O, 16'h0000, 3'd0, 4'd0);
        push(c + 20, "auto_relock", S_L, 16'h0000, 3'd0, 4'd0);
        wait_cyc(c + 20);

        // Non-digit keys and overflow digits are dropped; clear empties.
        key(4'd1);  push(chk_cyc, "entry_first", S_L, 16'h0001, 3'd1, 4'd0);
        key(4'hB);  push(chk_cyc, "non_bcd",     S_L, 16'h0001, 3'd1, 4'd0);
        key(4'd2); key(4'd3); key(4'd4);
        key(4'd5);  push(chk_cyc, "overflow",    S_L, 16'h1234, 3'd4, 4'd0);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(chk_cyc, "clear", S_L, 16'h0000, 3'd0, 4'd0);

        // Three wrong entries lock out for exactly 30 cycles.
        type4(4'd9, 4'd9, 4'd9, 4'd9); enter(); push(chk_cyc, "fail1", S_L, 16'h0, 3'd0, 4'd1);
        type4(4'd9, 4'd9, 4'd9, 4'd9); enter(); push(chk_cyc, "fail2", S_L, 16'h0, 3'd0, 4'd2);
        type4(4'd9, 4'd9, 4'd9, 4'd9); enter(); push(chk_cyc, "lockout", S_X, 16'h0, 3'd0, 4'd3);
        c = chk_cyc;
        key(4'd1); push(chk_cyc, "lo_key", S_X, 16'h0, 3'd0, 4'd3);
        key(4'd2); key(4'd3); key(4'd4);
        enter();   push(chk_cyc, "lo_enter", S_X, 16'h0, 3'd0, 4'd3);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        push(chk_cyc, "lo_cmds", S_X, 16'h0, 3'd0, 4'd3);
        push(c + 29, "lo_hold", S_X, 16'h0, 3'd0, 4'd3);
        push(c + 30, "lo_end",  S_L, 16'h0, 3'd0, 4'd0);
        wait_cyc(c + 30);

        // Enter and clear together: clear wins, failure count untouched.
        type4(4'd9, 4'd9, 4'd9, 4'd9); enter(); push(chk_cyc, "fail_pre", S_L, 16'h0, 3'd0, 4'd1);
        key(4'd9);
        step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        push(chk_cyc, "enter_clear", S_L, 16'h0, 3'd0, 4'd1);

        // Mismatched confirmation returns to OPEN with the timer reloaded.
        type4(4'd1, 4'd2, 4'd3, 4'd4); enter(); push(chk_cyc, "open2", S_O, 16'h0, 3'd0, 4'd0);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        push(chk_cyc, "prog1", S_P, 16'h0, 3'd0, 4'd0);
        key(4'd5); enter(); push(chk_cyc, "prog1_short", S_P, 16'h0, 3'd0, 4'd0);
        type4(4'd5, 4'd6, 4'd7, 4'd8); push(chk_cyc, "prog1_entry", S_P, 16'h5678, 3'd4, 4'd0);
        enter(); push(chk_cyc, "prog2", S_P, 16'h0, 3'd0, 4'd0);
        type4(4'd5, 4'd6, 4'd7, 4'd9); enter();
        push(chk_cyc, "prog2_mismatch", S_O, 16'h0, 3'd0, 4'd0);
        c = chk_cyc;
        push(c + 19, "reload_hold", S_O, 16'h0, 3'd0, 4'd0);
        push(c + 20, "reload_end",  S_L, 16'h0, 3'd0, 4'd0);
        wait_cyc(c + 20);
        type4(4'd1, 4'd2, 4'd3, 4'd4); enter(); push(chk_cyc, "old_code_kept", S_O, 16'h0, 3'd0, 4'd0);

        // Successful re-programming to 5678.
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        type4(4'd5, 4'd6, 4'd7, 4'd8); enter();
        type4(4'd5, 4'd6, 4'd7, 4'd8); enter(); push(chk_cyc, "prog_commit", S_L, 16'h0, 3'd0, 4'd0);
        type4(4'd1, 4'd2, 4'd3, 4'd4); enter(); push(chk_cyc, "old_rejected", S_L, 16'h0, 3'd0, 4'd1);
        type4(4'd5, 4'd6, 4'd7, 4'd8); enter(); push(chk_cyc, "new_opens", S_O, 16'h0, 3'd0, 4'd0);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(chk_cyc, "prog_relock", S_L, 16'h0, 3'd0, 4'd0);
        type4(4'd5, 4'd6, 4'd7, 4'd8); enter(); push(chk_cyc, "open3", S_O, 16'h0, 3'd0, 4'd0);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(chk_cyc, "open_relock", S_L, 16'h0, 3'd0, 4'd0);

        // Reset mid-LOCKOUT restores reset outputs and the default code.
        type4(4'd1, 4'd2, 4'd3, 4'd4); enter();
        type4(4'd1, 4'd2, 4'd3, 4'd4); enter();
        type4(4'd1, 4'd2, 4'd3, 4'd4); enter(); push(chk_cyc, "lockout2", S_X, 16'h0, 3'd0, 4'd3);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b0;
        push(cyc + 1, "reset_in_lockout", S_L, 16'h0, 3'd0, 4'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        type4(4'd5, 4'd6, 4'd7, 4'd8); enter(); push(chk_cyc, "default_restored", S_L, 16'h0, 3'd0, 4'd1);
        type4(4'd1, 4'd2, 4'd3, 4'd4); enter(); push(chk_cyc, "default_opens", S_O, 16'h0, 3'd0, 4'd0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_tests += q.size();
            n_fail  += q.size();
            $display("FAIL drain: %0d expectations never checked, required 0", q.size());
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
